// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Brief    : Pipeline-to-hazard-unit signal bundle (register tags in,
//             stall/flush/forward controls out).
//  Revision : 1.0
// ============================================================================
interface hazard_ctrl_if;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM;
    logic       branchD, pcsrcD, div_startE;
    logic       stallF, stallD, stallE;
    logic       flushD, flushE, flushM;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       div_busy, div_done;

    // The pipeline side drives the register tags and reads the controls.
    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, pcsrcD, div_startE,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAD, forwardBD, forwardAE, forwardBE, div_busy, div_done
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, pcsrcD, div_startE,
        output stallF, stallD, stallE, flushD, flushE, flushM,
               forwardAD, forwardBD, forwardAE, forwardBE, div_busy, div_done
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : 5-stage pipeline hazard unit: forwarding, load-use/branch
//             stalls, branch flush and multi-cycle divide stall sequencer.
//  Revision : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [5:0] c_cnt_load = 6'(DIV_CYCLES - 1);

    div_state_t r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic       w_lwstall, w_brstall, w_divstall, w_hazstall;
    logic       w_e_hits_d, w_m_hits_d;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w
    );
        if (src != 5'd0 && rw_m && wr_m == src)
            return 2'b10;
        else if (src != 5'd0 && rw_w && wr_w == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (hz.div_startE) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            S_BUSY: begin
                if (r_cnt == 6'd0)
                    w_state_nxt = S_DONE;
                else
                    w_cnt_nxt = r_cnt - 6'd1;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Zero-register destinations never create a dependency.
    always_comb begin
        w_e_hits_d = (hz.writeregE != 5'd0) &&
                     (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
        w_m_hits_d = (hz.writeregM != 5'd0) &&
                     (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD);
        w_lwstall  = hz.memtoregE && w_e_hits_d;
        w_brstall  = hz.branchD && ((hz.regwriteE && w_e_hits_d) ||
                                    (hz.memtoregM && w_m_hits_d));
        w_divstall = ((r_state == S_IDLE) && hz.div_startE) || (r_state == S_BUSY);
        w_hazstall = w_lwstall | w_brstall;
    end

    always_comb begin
        hz.forwardAE = fwd_sel(hz.rsE, hz.regwriteM, hz.writeregM,
                               hz.regwriteW, hz.writeregW);
        hz.forwardBE = fwd_sel(hz.rtE, hz.regwriteM, hz.writeregM,
                               hz.regwriteW, hz.writeregW);
        hz.forwardAD = (hz.rsD != 5'd0) && hz.regwriteM && (hz.writeregM == hz.rsD);
        hz.forwardBD = (hz.rtD != 5'd0) && hz.regwriteM && (hz.writeregM == hz.rtD);
    end

    // A divide freezes IF..EX and bubbles MEM; it overrides every other hazard.
    always_comb begin
        hz.stallF = w_hazstall;
        hz.stallD = w_hazstall;
        hz.stallE = 1'b0;
        hz.flushE = w_hazstall;
        hz.flushM = 1'b0;
        hz.flushD = hz.pcsrcD && !w_hazstall;
        if (w_divstall) begin
            hz.stallF = 1'b1;
            hz.stallD = 1'b1;
            hz.stallE = 1'b1;
            hz.flushE = 1'b0;
            hz.flushM = 1'b1;
            hz.flushD = 1'b0;
        end
        hz.div_busy = (r_state == S_BUSY);
        hz.div_done = (r_state == S_DONE);
    end
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Self-checking bench: directed vector table, divide/reset
//             sequences and randomized traffic against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference divider: number of BUSY cycles still to run, plus a DONE flag.
    int   m_left = 0;
    bit   m_done = 1'b0;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.DIV_CYCLES(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rsD, rtD, rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM, brD, pcD;
        logic [11:0] exp;
    } vec_t;

    vec_t tbl [12];

    function automatic logic [11:0] get_out();
        return {hz.stallF, hz.stallD, hz.stallE, hz.flushD, hz.flushE, hz.flushM,
                hz.forwardAD, hz.forwardBD, hz.forwardAE, hz.forwardBE};
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (r != 0 && hz.regwriteM && hz.writeregM == r) return 2'b10;
        if (r != 0 && hz.regwriteW && hz.writeregW == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_out();
        logic lw, br, ds, hs, fd, sF, sE, fE, fM;
        lw = hz.memtoregE && hz.writeregE != 0 &&
             (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD);
        br = hz.branchD &&
             ((hz.regwriteE && hz.writeregE != 0 &&
               (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
              (hz.memtoregM && hz.writeregM != 0 &&
               (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)));
        ds = (m_left == 0 && !m_done && hz.div_startE) || (m_left > 0);
        hs = lw | br;
        sF = ds ? 1'b1 : hs;
        sE = ds;
        fE = ds ? 1'b0 : hs;
        fM = ds;
        fd = ds ? 1'b0 : (hz.pcsrcD && !hs);
        return {sF, sF, sE, fd, fE, fM,
                (hz.rsD != 0 && hz.regwriteM && hz.writeregM == hz.rsD),
                (hz.rtD != 0 && hz.regwriteM && hz.writeregM == hz.rtD),
                ref_fwd(hz.rsE), ref_fwd(hz.rtE)};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_done = 1'b1;
        end else if (hz.div_startE) begin
            m_left = DIV;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic clear_in();
        hz.rsD = 0; hz.rtD = 0; hz.rsE = 0; hz.rtE = 0;
        hz.writeregE = 0; hz.writeregM = 0; hz.writeregW = 0;
        hz.regwriteE = 0; hz.regwriteM = 0; hz.regwriteW = 0;
        hz.memtoregE = 0; hz.memtoregM = 0;
        hz.branchD = 0; hz.pcsrcD = 0; hz.div_startE = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        hz.rsD = v.rsD; hz.rtD = v.rtD; hz.rsE = v.rsE; hz.rtE = v.rtE;
        hz.writeregE = v.wE; hz.writeregM = v.wM; hz.writeregW = v.wW;
        hz.regwriteE = v.rwE; hz.regwriteM = v.rwM; hz.regwriteW = v.rwW;
        hz.memtoregE = v.mtrE; hz.memtoregM = v.mtrM;
        hz.branchD = v.brD; hz.pcsrcD = v.pcD; hz.div_startE = 1'b0;
    endtask

    initial begin
        //            name         rsD  rtD  rsE  rtE  wE   wM   wW  rwE rwM rwW mtE mtM brD pcD  {sF sD sE fD fE fM aD bD AE BE}
        tbl[0]  = '{"lu_rs",      8,   0,   0,   0,   8,   0,   0,  0,  0,  0,  1,  0,  0,  0, 12'b110010_00_0000};
        tbl[1]  = '{"lu_r0",      8,   0,   0,   0,   0,   0,   0,  0,  0,  0,  1,  0,  0,  0, 12'b000000_00_0000};
        tbl[2]  = '{"fwd_mem",    0,   0,   5,   0,   0,   5,   5,  0,  1,  1,  0,  0,  0,  0, 12'b000000_00_1000};
        tbl[3]  = '{"fwd_wb",     0,   0,   5,   0,   0,   5,   5,  0,  0,  1,  0,  0,  0,  0, 12'b000000_00_0100};
        tbl[4]  = '{"fwd_r0",     0,   0,   0,   0,   0,   5,   5,  0,  1,  1,  0,  0,  0,  0, 12'b000000_00_0000};
        tbl[5]  = '{"br_taken",   0,   0,   0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  0,  1, 12'b000100_00_0000};
        tbl[6]  = '{"br_held",    7,   0,   0,   0,   7,   0,   0,  1,  0,  0,  0,  0,  1,  1, 12'b110010_00_0000};
        tbl[7]  = '{"fwd_d",      3,   4,   0,   3,   0,   3,   0,  0,  1,  0,  0,  0,  0,  0, 12'b000000_10_0010};
        tbl[8]  = '{"lu_rt",      0,   9,   0,   0,   9,   0,   0,  0,  0,  0,  1,  0,  0,  0, 12'b110010_00_0000};
        tbl[9]  = '{"br_memld",   0,   6,   0,   0,   0,   6,   0,  0,  0,  0,  0,  1,  1,  0, 12'b110010_00_0000};
        tbl[10] = '{"br_r0",      0,   0,   0,   0,   0,   0,   0,  1,  0,  0,  0,  0,  1,  1, 12'b000100_00_0000};
        tbl[11] = '{"fwd_wb_rt",  0,   0,   0,  12,   0,   0,  12,  0,  0,  1,  0,  0,  0,  0, 12'b000000_00_0001};

        clear_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_busy", {11'd0, hz.div_busy}, 12'd0);
        chk("reset_done", {11'd0, hz.div_done}, 12'd0);
        chk("reset_outs", get_out(), 12'd0);

        for (int i = 0; i < 12; i++) begin
            apply_vec(tbl[i]);
            #1;
            chk(tbl[i].name, get_out(), tbl[i].exp);
        end

        // Divide of DIV busy cycles; start is ignored while in DONE.
        clear_in();
        step();
        hz.div_startE = 1'b1;
        #1;
        chk("div_start_stallE", {11'd0, hz.stallE}, 12'd1);
        chk("div_start_busy", {11'd0, hz.div_busy}, 12'd0);
        step();
        hz.div_startE = 1'b0;
        for (int i = 0; i < DIV; i++) begin
            #1;
            chk("div_busy_stallE", {11'd0, hz.stallE}, 12'd1);
            chk("div_busy_flag", {10'd0, hz.div_busy, hz.div_done}, 12'b10);
            step();
        end
        #1;
        chk("div_done_flag", {10'd0, hz.div_busy, hz.div_done}, 12'b01);
        chk("div_done_stallE", {11'd0, hz.stallE}, 12'd0);
        hz.div_startE = 1'b1;
        #1;
        chk("div_done_ignore", {11'd0, hz.stallE}, 12'd0);
        step();
        hz.div_startE = 1'b0;
        #1;
        chk("div_back_idle", {9'd0, hz.div_busy, hz.div_done, hz.stallE}, 12'd0);

        // Divide overrides load-use and taken-branch while BUSY.
        hz.div_startE = 1'b1;
        step();
        hz.div_startE = 1'b0;
        hz.memtoregE = 1'b1; hz.writeregE = 8; hz.rsD = 8; hz.pcsrcD = 1'b1;
        #1;
        chk("div_over_haz", get_out(), 12'b111001_00_0000);
        clear_in();
        for (int i = 0; i < DIV + 1; i++) step();
        #1;
        chk("div_over_idle", {10'd0, hz.div_busy, hz.div_done}, 12'd0);

        // Reset in the second BUSY cycle aborts the divide.
        hz.div_startE = 1'b1;
        step();
        hz.div_startE = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy_before", {11'd0, hz.div_busy}, 12'd1);
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_after", {10'd0, hz.div_busy, hz.stallE}, 12'd0);
        for (int i = 0; i < DIV + 2; i++) begin
            chk("rst_mid_no_done", {11'd0, hz.div_done}, 12'd0);
            step();
            #1;
        end

        // Reset wins over a same-cycle start.
        rst = 1'b1;
        hz.div_startE = 1'b1;
        #1;
        chk("rst_start_comb", {11'd0, hz.stallE}, 12'd1);
        step();
        rst = 1'b0;
        hz.div_startE = 1'b0;
        #1;
        chk("rst_start_idle", {10'd0, hz.div_busy, hz.stallE}, 12'd0);

        for (int i = 0; i < 1500; i++) begin
            hz.rsD = 5'($urandom_range(0, 3)); hz.rtD = 5'($urandom_range(0, 3));
            hz.rsE = 5'($urandom_range(0, 3)); hz.rtE = 5'($urandom_range(0, 3));
            hz.writeregE = 5'($urandom_range(0, 3));
            hz.writeregM = 5'($urandom_range(0, 3));
            hz.writeregW = 5'($urandom_range(0, 3));
            hz.regwriteE = 1'($urandom_range(0, 1)); hz.regwriteM = 1'($urandom_range(0, 1));
            hz.regwriteW = 1'($urandom_range(0, 1)); hz.memtoregE = 1'($urandom_range(0, 1));
            hz.memtoregM = 1'($urandom_range(0, 1)); hz.branchD = 1'($urandom_range(0, 1));
            hz.pcsrcD = 1'($urandom_range(0, 1));
            hz.div_startE = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 49) == 0);
            #1;
            chk("rnd_outs", get_out(), model_out());
            chk("rnd_flags", {10'd0, hz.div_busy, hz.div_done},
                {10'd0, (m_left > 0), m_done});
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_CYCLES, default 32, giving the number of BUSY cycles of a multi-cycle divide (legal range 2..63).
REQ-002 The block SHALL have the following ports, clock and reset first:
  clk          in   1   single clock; all state updates on posedge
  rst          in   1   synchronous, active-high reset
  rsD, rtD     in   5   source register numbers of the instruction in ID
  rsE, rtE     in   5   source register numbers of the instruction in EX
  writeregE/M/W  in  5  destination register in EX/MEM/WB
  regwriteE/M/W  in  1  destination write enable in EX/MEM/WB
  memtoregE/M  in   1   load instruction in EX/MEM
  branchD      in   1   branch/jr in ID needs operands
  pcsrcD       in   1   branch in ID resolved taken
  div_startE   in   1   div/divu in EX
  stallF, stallD, stallE  out  1  hold the PC, IF/ID and ID/EX registers
  flushD, flushE, flushM  out  1  clear the IF/ID, ID/EX and EX/MEM registers
  forwardAD, forwardBD    out  1  forward ALU result from MEM to the ID comparator
  forwardAE, forwardBE    out  2  EX operand select: 00 register file, 01 WB, 10 MEM
  div_busy     out  1   divider FSM is in BUSY
  div_done     out  1   one-cycle pulse in DONE

Function
REQ-003 Forwarding SHALL be combinational. forwardAE SHALL be 10 when rsE!=0 && regwriteM && writeregM==rsE, else 01 when rsE!=0 && regwriteW && writeregW==rsE, else 00. forwardBE SHALL follow the same rule using rtE. MEM SHALL have priority over WB.
REQ-004 forwardAD SHALL be asserted when rsD!=0 && regwriteM && writeregM==rsD. forwardBD SHALL use the same rule with rtD.
REQ-005 lwstall SHALL be asserted when memtoregE && writeregE!=0 && (writeregE==rsD || writeregE==rtD).
REQ-006 brstall SHALL be asserted when branchD && writeregX!=0 && writeregX matches rsD or rtD, for either (X=E and regwriteE) or (X=M and memtoregM).
REQ-007 The divider FSM SHALL have the states IDLE, BUSY and DONE, with a 6-bit down-counter cnt:
  IDLE to BUSY when div_startE; cnt loads DIV_CYCLES-1.
  BUSY: cnt decrements each cycle; when cnt==0 the FSM goes to DONE.
  DONE to IDLE unconditionally. div_startE SHALL be ignored in DONE.
REQ-008 divstall SHALL be (IDLE && div_startE) || BUSY. A divide SHALL therefore stall the pipeline for exactly DIV_CYCLES+1 cycles, followed by DONE.
REQ-009 When divstall=1, the outputs SHALL be stallF=stallD=stallE=1, flushM=1, flushE=0 and flushD=0, regardless of lwstall, brstall or pcsrcD.
REQ-010 When divstall=0, the outputs SHALL be stallF=stallD=flushE=lwstall|brstall, stallE=0 and flushM=0.
REQ-011 When divstall=0, flushD SHALL be pcsrcD && !stallD. A taken branch that is held by a stall SHALL NOT flush IF/ID.
REQ-012 div_busy SHALL be 1 only in BUSY. div_done SHALL be 1 only in DONE.
REQ-013 All outputs other than div_busy and div_done SHALL be combinational from the inputs and the FSM state, with no added latency.

Reset
REQ-014 On rst=1 at a clock edge, the FSM SHALL go to IDLE and cnt SHALL go to 0. This SHALL hold mid-division: div_busy=0 on the following cycle, and the stalls SHALL drop unless div_startE is still asserted.
REQ-015 After reset, div_busy=0 and div_done=0. All combinational outputs SHALL depend only on the current inputs.
REQ-016 rst SHALL take priority over div_startE in the same cycle.

Verification
REQ-017 Load-use: memtoregE=1, writeregE=8, rsD=8 -> stallF=stallD=flushE=1, flushM=0. Same stimulus with writeregE=0 -> all stall and flush outputs 0.
REQ-018 Forwarding priority: regwriteM=regwriteW=1, writeregM=writeregW=rsE=5 -> forwardAE=10. Clear regwriteM -> forwardAE=01. Set rsE=0 -> forwardAE=00.
REQ-019 Divide with DIV_CYCLES=4: pulse div_startE -> stallE high for 5 consecutive cycles, div_busy high for 4 cycles, then div_done high for 1 cycle with stallE=0, then FSM back in IDLE.
REQ-020 Divide concurrent with hazards: during BUSY, assert lwstall and pcsrcD conditions -> flushE=0 and flushD=0 while stallF/D/E=1 and flushM=1.
REQ-021 Taken branch: pcsrcD=1 with no hazard -> flushD=1. pcsrcD=1 with brstall (regwriteE=1, writeregE==rsD, branchD=1) -> flushD=0 and stallD=1.
REQ-022 Reset mid-division: assert rst on cycle 2 of BUSY with div_startE=0 -> next cycle div_busy=0, stallE=0, div_done never pulses.
